q_timing_queue: RTL and testbench

Timestamped issue queue directly downstream of the instruction decoder. It consumes the decoder's quantum timing strobes (`q_time_write`, `q_time_sel`) and quantum-operation pushes, and keeps a running timeline. Each pushed operation is tagged with the current timeline value and released to the pulse-generation backend when a free-running timer reaches that timestamp. This makes the classical pipeline's variable latency invisible to the quantum timing.

---
 rtl/q_timing_queue.sv | 129 ++++++++++++
 tb/tb_q_timing_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/q_timing_queue.sv
// Timestamped issue queue: each op is tagged with the running timeline T and released when timer_now reaches its tag (push-to-out_valid >= 2 cycles).
// q_op_ready drops when the queue is full or draining; out_* hold until out_ready. Optional lateness flag: QTQ_LATE_CHECK_EN.
module q_timing_queue #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 32,
  parameter int OP_W  = 32,
  parameter int IMM_W = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     q_time_write,
  input  logic                     q_time_sel,
  input  logic [IMM_W-1:0]         wait_imm,
  input  logic [TS_W-1:0]          wait_reg,
  input  logic                     q_op_valid,
  input  logic [OP_W-1:0]          q_op_data,
  output logic                     q_op_ready,
  input  logic                     stop,
  output logic                     out_valid,
  output logic [OP_W-1:0]          out_data,
  output logic [TS_W-1:0]          out_ts,
  input  logic                     out_ready,
  output logic [TS_W-1:0]          timer_now,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err,
  output logic                     late_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [TS_W-1:0] ts;
  } entry_t;

  state_t          state, state_nxt;
  logic [TS_W-1:0] timeline, timeline_nxt, timer_nxt;
  entry_t          mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  entry_t          head;
  logic            full, empty, push, load, head_due, drain_done;
  logic [TS_W-1:0] head_age, wait_sel;

  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (wr_ptr == rd_ptr);
  assign q_op_ready = !full && (state != DRAIN);
  assign push       = q_op_valid && q_op_ready;

  // Wrap-safe "timer >= ts": valid while outstanding spans stay below half the range.
  assign head       = mem[rd_ptr[AW-1:0]];
  assign head_age   = timer_now - head.ts;
  assign head_due   = !head_age[TS_W-1];
  assign load       = !empty && head_due && (!out_valid || out_ready);
  assign drain_done = (state == DRAIN) && empty && !out_valid;
  assign wait_sel   = q_time_sel ? wait_reg : TS_W'(wait_imm);

  always_comb begin
    state_nxt    = state;
    timeline_nxt = timeline;
    timer_nxt    = timer_now;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (q_time_write) timeline_nxt = timeline + wait_sel;
        if (push) state_nxt = RUN;
      end
      RUN: begin
        timer_nxt = timer_now + TS_W'(1);
        if (q_time_write) timeline_nxt = timeline + wait_sel;
        if (stop) state_nxt = DRAIN;
      end
      DRAIN: begin
        timer_nxt = timer_now + TS_W'(1);
        if (drain_done) begin
          state_nxt    = IDLE;
          timeline_nxt = '0;
          timer_nxt    = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timeline     <= '0;
      timer_now    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_ts       <= '0;
      overflow_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      timeline  <= timeline_nxt;
      timer_now <= timer_nxt;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (load) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= head.op;
        out_ts    <= head.ts;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (q_op_valid && !q_op_ready) overflow_err <= 1'b1;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{op: q_op_data, ts: timeline};
  end

`ifdef QTQ_LATE_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) late_err <= 1'b0;
    else if (load && (head_age > TS_W'(1))) late_err <= 1'b1;
  end
`else
  assign late_err = 1'b0;
`endif

endmodule

// File: tb/tb_q_timing_queue.sv
// Bench for q_timing_queue: directed scenarios plus random traffic, every cycle compared
// against a queue-based reference model of the timeline/timer/issue rules.
module tb_q_timing_queue;
  localparam int DEPTH = 8;
  localparam int TS_W  = 32;
  localparam int OP_W  = 32;
  localparam int IMM_W = 20;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_DRAIN = 2;
`ifdef QTQ_LATE_CHECK_EN
  localparam bit LATE_EN = 1'b1;
`else
  localparam bit LATE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, q_time_write, q_time_sel, q_op_valid, stop, out_ready;
  logic [IMM_W-1:0] wait_imm;
  logic [TS_W-1:0]  wait_reg;
  logic [OP_W-1:0]  q_op_data;
  logic q_op_ready, out_valid, overflow_err, late_err;
  logic [OP_W-1:0] out_data;
  logic [TS_W-1:0] out_ts, timer_now;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  q_timing_queue #(.DEPTH(DEPTH), .TS_W(TS_W), .OP_W(OP_W), .IMM_W(IMM_W)) dut (
    .clk(clk), .reset(reset), .q_time_write(q_time_write), .q_time_sel(q_time_sel),
    .wait_imm(wait_imm), .wait_reg(wait_reg), .q_op_valid(q_op_valid), .q_op_data(q_op_data),
    .q_op_ready(q_op_ready), .stop(stop), .out_valid(out_valid), .out_data(out_data),
    .out_ts(out_ts), .out_ready(out_ready), .timer_now(timer_now), .count(count),
    .overflow_err(overflow_err), .late_err(late_err)
  );

  typedef struct packed { logic [31:0] op; logic [31:0] ts; } ent_t;
  ent_t        mq[$];
  int          m_state;
  logic [31:0] m_T, m_timer, m_od, m_ots;
  bit          m_ov, m_ovf, m_late;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_state = ST_IDLE; m_T = 0; m_timer = 0; m_od = 0; m_ots = 0;
    m_ov = 0; m_ovf = 0; m_late = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit rdy, push, load, exitd;
    logic [31:0] age, w;
    ent_t h;
    int old;
    if (reset) begin model_reset(); return; end
    old   = m_state;
    rdy   = (mq.size() < DEPTH) && (m_state != ST_DRAIN);
    push  = q_op_valid && rdy;
    if (q_op_valid && !rdy) m_ovf = 1;
    load  = 0;
    age   = 0;
    if (mq.size() > 0) begin
      age  = m_timer - mq[0].ts;
      load = !age[31] && (!m_ov || out_ready);
    end
    exitd = (old == ST_DRAIN) && (mq.size() == 0) && !m_ov;
    w     = q_time_sel ? wait_reg : 32'(wait_imm);
    if (load) begin
      h = mq.pop_front();
      if (LATE_EN && age > 1) m_late = 1;
      m_ov = 1; m_od = h.op; m_ots = h.ts;
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
    if (push) mq.push_back('{op: q_op_data, ts: m_T});
    if (exitd) begin
      m_state = ST_IDLE; m_T = 0; m_timer = 0;
    end else begin
      if (q_time_write && old != ST_DRAIN) m_T = m_T + w;
      m_timer = (old == ST_IDLE) ? 0 : m_timer + 1;
      if (old == ST_IDLE && push) m_state = ST_RUN;
      if (old == ST_RUN && stop) m_state = ST_DRAIN;
    end
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("out_ts", out_ts, m_ots);
    chk("count", count, mq.size());
    chk("timer_now", timer_now, m_timer);
    chk("q_op_ready", q_op_ready, (mq.size() < DEPTH) && (m_state != ST_DRAIN));
    chk("overflow_err", overflow_err, m_ovf);
    chk("late_err", late_err, m_late);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    bit seen_bad;
    logic [31:0] got[$];

    reset = 1; q_time_write = 0; q_time_sel = 0; wait_imm = 0; wait_reg = 0;
    q_op_valid = 0; q_op_data = 0; stop = 0; out_ready = 1;
    model_reset();
    step(); step();
    reset = 0;
    chk("rst_count", count, 0);
    chk("rst_timer", timer_now, 0);
    chk("rst_out_valid", out_valid, 0);

    // Op A in IDLE, then wait 10, then op B.
    q_op_valid = 1; q_op_data = 32'hA; step();
    q_op_valid = 0; q_time_write = 1; q_time_sel = 0; wait_imm = 10; step();
    q_time_write = 0;
    chk("A_valid", out_valid, 1);
    chk("A_data", out_data, 32'hA);
    chk("A_ts", out_ts, 0);
    q_op_valid = 1; q_op_data = 32'hB; step();
    q_op_valid = 0;
    for (int i = 0; i < 30 && timer_now != 10; i++) step();
    chk("B_timer_reach", timer_now, 10);
    step();
    chk("B_valid", out_valid, 1);
    chk("B_ts", out_ts, 10);
    chk("B_data", out_data, 32'hB);
    step();

    // Timeline wrap: 0x0A + 0x16 = 0x20, then + 0xFFFF_FFF0 = 0x10.
    q_time_write = 1; q_time_sel = 0; wait_imm = 20'h16; step();
    q_time_sel = 1; wait_reg = 32'hFFFF_FFF0; step();
    q_time_write = 0; q_time_sel = 0;
    q_op_valid = 1; q_op_data = 32'hC; step();
    q_op_valid = 0;
    for (int i = 0; i < 40 && !out_valid; i++) step();
    chk("C_ts_wrap", out_ts, 32'h10);
    chk("C_data", out_data, 32'hC);

    // Overflow: fill with not-yet-due entries, then a ninth push.
    out_ready = 0;
    q_time_write = 1; wait_imm = 100; step();
    q_time_write = 0;
    for (int k = 0; k < DEPTH; k++) begin
      q_op_valid = 1; q_op_data = 32'h100 + k; step();
    end
    q_op_valid = 0;
    chk("ovf_count", count, DEPTH);
    chk("ovf_ready", q_op_ready, 0);
    q_op_valid = 1; q_op_data = 32'hDEAD; step();
    q_op_valid = 0;
    chk("ovf_err", overflow_err, 1);
    chk("ovf_count_hold", count, DEPTH);
    out_ready = 1; stop = 1; step(); stop = 0;
    seen_bad = 0;
    for (int i = 0; i < 400 && m_state != ST_IDLE; i++) begin
      q_op_valid = (m_state == ST_DRAIN); q_op_data = 32'hBEEF;
      step();
      if (out_valid && (out_data == 32'hDEAD || out_data == 32'hBEEF)) seen_bad = 1;
    end
    q_op_valid = 0;
    chk("ovf_dropped", seen_bad, 0);
    chk("ovf_idle_timer", timer_now, 0);

    // Stop with three entries queued.
    q_time_write = 1; wait_imm = 5; step();
    q_time_write = 0;
    for (int k = 1; k <= 3; k++) begin
      q_op_valid = 1; q_op_data = 32'h300 + k; step();
    end
    q_op_valid = 0;
    stop = 1; step(); stop = 0;
    chk("drain_ready", q_op_ready, 0);
    for (int i = 0; i < 100 && m_state != ST_IDLE; i++) begin
      q_op_valid = (m_state == ST_DRAIN); q_op_data = 32'h3FF;
      step();
      if (out_valid) got.push_back(out_data);
    end
    q_op_valid = 0;
    chk("drain_n", got.size(), 3);
    for (int k = 0; k < 3 && k < got.size(); k++) chk("drain_order", got[k], 32'h301 + k);
    chk("drain_timer", timer_now, 0);
    chk("drain_count", count, 0);

    // Lateness: second due entry stuck behind a held output.
    reset = 1; step(); reset = 0;
    chk("late_clear", late_err, 0);
    out_ready = 0;
    q_op_valid = 1; q_op_data = 32'h501; step();
    q_op_data = 32'h502; step();
    q_op_valid = 0;
    for (int i = 0; i < 6; i++) step();
    chk("late_pre", late_err, 0);
    out_ready = 1; step();
    chk("late_set", late_err, LATE_EN);
    chk("late_issue", out_data, 32'h502);
    step();

    // Reset with four entries queued and the output register full.
    out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      q_op_valid = 1; q_op_data = 32'h600 + k; step();
    end
    q_op_valid = 0;
    chk("prerst_count", count, 4);
    chk("prerst_valid", out_valid, 1);
    reset = 1; step(); reset = 0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_ts", out_ts, 0);
    chk("midrst_count", count, 0);
    chk("midrst_timer", timer_now, 0);
    chk("midrst_ovf", overflow_err, 0);
    out_ready = 1; seen_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid) seen_bad = 1;
    end
    chk("midrst_silent", seen_bad, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 799) == 0);
      q_op_valid   = ($urandom_range(0, 1) == 1);
      q_op_data    = $urandom;
      q_time_write = ($urandom_range(0, 3) == 0);
      q_time_sel   = ($urandom_range(0, 1) == 1);
      wait_imm     = IMM_W'($urandom_range(0, 7));
      wait_reg     = $urandom_range(0, 7);
      out_ready    = ($urandom_range(0, 9) < 7);
      stop         = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
